// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and address window defaults for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [31:0] DEFAULT_MEM_BASE  = 32'h7FFF0000;
  localparam logic [31:0] DEFAULT_MEM_LIMIT = 32'h7FFFFFFF;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  // Only the fields needed after accept: the word address lives in mem_address,
  // and word-store data goes straight to mem_write_data.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  offset;
    logic [15:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_lane_mux.sv
// rtl/lsu_lane_mux.sv - big-endian byte/half lane select, store merge, load extension and alignment check
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    merged    = rdata;
    load_data = rdata;
    misalign  = 1'b0;
    lane_b    = 8'h00;
    lane_h    = 16'h0000;
    case (size)
      SIZE_BYTE: begin
        // Offset 0 is the most significant byte.
        case (offset)
          2'd0: begin lane_b = rdata[31:24]; merged[31:24] = wdata[7:0]; end
          2'd1: begin lane_b = rdata[23:16]; merged[23:16] = wdata[7:0]; end
          2'd2: begin lane_b = rdata[15:8];  merged[15:8]  = wdata[7:0]; end
          default: begin lane_b = rdata[7:0]; merged[7:0] = wdata[7:0]; end
        endcase
        load_data = {{24{is_signed & lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        if (offset[1]) begin
          lane_h       = rdata[15:0];
          merged[15:0] = wdata;
        end else begin
          lane_h        = rdata[31:16];
          merged[31:16] = wdata;
        end
        load_data = {{16{is_signed & lane_h[15]}}, lane_h};
        misalign  = offset[0];
      end
      SIZE_WORD: misalign = (offset != 2'd0);
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with sub-word RMW; LSU_BOUNDS_CHECK_EN enables address window check
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] MEM_BASE     = DEFAULT_MEM_BASE,
  parameter logic [31:0] MEM_LIMIT    = DEFAULT_MEM_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);
`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  lsu_state_t  state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  lsu_req_t    req_q, req_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic        err_d;

  logic [1:0]  mux_offset, mux_size;
  logic        mux_signed, misalign;
  logic [31:0] merged, load_data;
  logic        accept, out_of_bounds, req_err;

  assign req_ready  = rst_n && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign mem_write  = (state_q == WRITE);
  assign resp_valid = (state_q == RESP);

  // The lane mux checks alignment of the incoming request in IDLE and
  // serves the captured request in every other state.
  assign mux_offset = (state_q == IDLE) ? req_addr[1:0] : req_q.offset;
  assign mux_size   = (state_q == IDLE) ? req_size      : req_q.size;
  assign mux_signed = (state_q == IDLE) ? req_signed    : req_q.sgn;

  lsu_lane_mux u_lane_mux (
    .offset    (mux_offset),
    .size      (mux_size),
    .is_signed (mux_signed),
    .rdata     (mem_read_data),
    .wdata     (req_q.wdata),
    .merged    (merged),
    .load_data (load_data),
    .misalign  (misalign)
  );

  assign out_of_bounds = BOUNDS_EN && ((req_addr < MEM_BASE) || (req_addr > MEM_LIMIT));
  assign req_err       = misalign || (req_size == SIZE_RSVD) || out_of_bounds;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = mem_address;
    wdata_d = mem_write_data;
    rdata_d = resp_rdata;
    err_d   = resp_error;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d   = '{write: req_write, size: req_size, sgn: req_signed,
                      offset: req_addr[1:0], wdata: req_wdata[15:0]};
          wait_d  = 2'd0;
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_write && (req_size == SIZE_WORD)) begin
              wdata_d = req_wdata;
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (wait_q == LAST_WAIT) begin
          if (req_q.write) begin
            wdata_d = merged;
            state_d = WRITE;
          end else begin
            rdata_d = load_data;
            state_d = RESP;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_q         <= 2'd0;
      req_q          <= '0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      resp_rdata     <= 32'h0;
      resp_error     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      req_q          <= req_d;
      mem_address    <= addr_d;
      mem_write_data <= wdata_d;
      resp_rdata     <= rdata_d;
      resp_error     <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a small word memory model
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  load_store_unit #(.READ_LATENCY(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Single-latency memory: data for the address presented in a cycle is sampled at the next edge.
  assign mem_read_data = mem[mem_address[5:2]];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[5]  = 32'h12F45678;
    mem[6]  = 32'h11223344;
    mem[15] = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      if (mem_write) mem[mem_address[5:2]] = mem_write_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdat;
  } vec_t;

  function automatic vec_t mk(string n, logic w, logic [1:0] sz, logic sg, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic er, int lat, int nwr,
                              logic [31:0] waddr, logic [31:0] wdat);
    vec_t v;
    v.name = n; v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.exp_rd = rd; v.exp_er = er; v.exp_lat = lat; v.exp_nwr = nwr;
    v.exp_waddr = waddr; v.exp_wdat = wdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int nwr, output logic [31:0] waddr,
                         output logic [31:0] wdat, output logic [31:0] addr_before,
                         output logic [31:0] addr_after);
    @(negedge clk);
    addr_before = mem_address;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nwr = 0; rd = 32'h0; er = 1'b0; waddr = 32'h0; wdat = 32'h0; addr_after = 32'h0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_write) begin
        nwr++;
        waddr = mem_address;
        wdat  = mem_write_data;
      end
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_error;
        addr_after = mem_address;
        break;
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, waddr, wdat, ab, aa;
    logic        er;
    int          lat, nwr, wcount, first_at, second_at;
    logic [31:0] rd1, rd2;
    logic        rdy [1:5];
    logic        switched;

    vecs.push_back(mk("sw",       1, SIZE_WORD, 0, 32'h7FFF0010, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'h7FFF0010, 32'hDEADBEEF));
    vecs.push_back(mk("lw",       0, SIZE_WORD, 0, 32'h7FFF0010, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lb_s",     0, SIZE_BYTE, 1, 32'h7FFF0015, 32'h0,        32'hFFFFFFF4, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lbu",      0, SIZE_BYTE, 0, 32'h7FFF0015, 32'h0,        32'h000000F4, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("sb_rmw",   1, SIZE_BYTE, 0, 32'h7FFF001A, 32'hFFFFFFAA, 32'h0,        0, 3, 1, 32'h7FFF0018, 32'h1122AA44));
    vecs.push_back(mk("lw_rmw",   0, SIZE_WORD, 0, 32'h7FFF0018, 32'h0,        32'h1122AA44, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lh_mis",   0, SIZE_HALF, 1, 32'h7FFF0001, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0));
    vecs.push_back(mk("sw_mis",   1, SIZE_WORD, 0, 32'h7FFF0002, 32'h12345678, 32'h0,        1, 1, 0, 32'h0, 32'h0));
    vecs.push_back(mk("rsvd",     0, SIZE_RSVD, 0, 32'h7FFF0010, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lh_s",     0, SIZE_HALF, 1, 32'h7FFF0010, 32'h0,        32'hFFFFDEAD, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lhu",      0, SIZE_HALF, 0, 32'h7FFF0010, 32'h0,        32'h0000DEAD, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("sh_rmw",   1, SIZE_HALF, 0, 32'h7FFF0012, 32'h1234CAFE, 32'h0,        0, 3, 1, 32'h7FFF0010, 32'hDEADCAFE));
    vecs.push_back(mk("lb_o3",    0, SIZE_BYTE, 1, 32'h7FFF0013, 32'h0,        32'hFFFFFFFE, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lbu_o0",   0, SIZE_BYTE, 0, 32'h7FFF0010, 32'h0,        32'h000000DE, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("sb_o0",    1, SIZE_BYTE, 0, 32'h7FFF0014, 32'h00000080, 32'h0,        0, 3, 1, 32'h7FFF0014, 32'h80F45678));
    vecs.push_back(mk("lb_s_o0",  0, SIZE_BYTE, 1, 32'h7FFF0014, 32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lh_o2",    0, SIZE_HALF, 1, 32'h7FFF0016, 32'h0,        32'h00005678, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lw_wrap",  0, SIZE_WORD, 0, 32'hFFFFFFFC, 32'h0,        32'hA5A5A5A5, 0, 2, 0, 32'h0, 32'h0));
    vecs.push_back(mk("lbu_wrap", 0, SIZE_BYTE, 0, 32'hFFFFFFFF, 32'h0,        32'h000000A5, 0, 2, 0, 32'h0, 32'h0));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_write",  {31'h0, mem_write},  32'h0);
    check("rst_mem_addr",   mem_address,         32'h0);
    check("rst_mem_wdata",  mem_write_data,      32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata,          32'h0);
    check("rst_resp_error", {31'h0, resp_error}, 32'h0);
    rst_n = 1'b1;
    #1 check("rst_ready_after", {31'h0, req_ready}, 32'h1);

    foreach (vecs[i]) begin
      run_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
              rd, er, lat, nwr, waddr, wdat, ab, aa);
      check({vecs[i].name, "_rdata"},   rd,          vecs[i].exp_rd);
      check({vecs[i].name, "_error"},   {31'h0, er}, {31'h0, vecs[i].exp_er});
      check({vecs[i].name, "_latency"}, 32'(lat),    32'(vecs[i].exp_lat));
      check({vecs[i].name, "_writes"},  32'(nwr),    32'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0) begin
        check({vecs[i].name, "_waddr"}, waddr, vecs[i].exp_waddr);
        check({vecs[i].name, "_wdata"}, wdat,  vecs[i].exp_wdat);
      end
      if (vecs[i].exp_er) check({vecs[i].name, "_addr_held"}, aa, ab);
    end

    // Reset while an SH is in READ: nothing may be written afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_HALF; req_signed = 1'b0;
    req_addr = 32'h7FFF0018; req_wdata = 32'h0000BBBB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_write",  {31'h0, mem_write},  32'h0);
    check("midrst_mem_addr",   mem_address,         32'h0);
    check("midrst_mem_wdata",  mem_write_data,      32'h0);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst_resp_rdata", resp_rdata,          32'h0);
    check("midrst_resp_error", {31'h0, resp_error}, 32'h0);
    check("midrst_ready",      {31'h0, req_ready},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_write) wcount++;
    end
    check("midrst_no_write",   32'(wcount),        32'h0);
    check("midrst_word_kept",  mem[6],             32'h1122AA44);
    check("midrst_ready_back", {31'h0, req_ready}, 32'h1);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h7FFF0010; req_wdata = 32'h0;
    @(posedge clk);
    first_at = 0; second_at = 0; rd1 = 32'h0; rd2 = 32'h0; switched = 1'b0;
    for (int i = 1; i <= 5; i++) rdy[i] = 1'bx;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 5) rdy[n] = req_ready;
      if (resp_valid && !switched) begin
        first_at = n;
        rd1 = resp_rdata;
        switched = 1'b1;
        req_addr = 32'h7FFF0018;
      end else if (resp_valid && switched) begin
        second_at = n;
        rd2 = resp_rdata;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    check("b2b_first_resp_at",  32'(first_at),     32'd2);
    check("b2b_second_resp_at", 32'(second_at),    32'd5);
    check("b2b_first_rdata",    rd1,               32'hDEADCAFE);
    check("b2b_second_rdata",   rd2,               32'h1122AA44);
    check("b2b_ready_read",     {31'h0, rdy[1]},   32'h0);
    check("b2b_ready_resp",     {31'h0, rdy[2]},   32'h0);
    check("b2b_ready_idle",     {31'h0, rdy[3]},   32'h1);
    check("b2b_ready_read2",    {31'h0, rdy[4]},   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for word-wide data memory. Accepts one load/store request from the MEM stage and drives mem_write, mem_address and mem_write_data.
- Captures mem_read_data and returns sign- or zero-extended load data.
- Implements byte and halfword stores (SB/SH) as read-modify-write on 32-bit words.
- Big-endian, MIPS byte lanes.

Parameters:
- READ_LATENCY, 1: cycles between presenting mem_address and sampling mem_read_data (1..4).
- MEM_BASE, 32'h7FFF0000: lowest legal byte address (bounds-check feature only).
- MEM_LIMIT, 32'h7FFFFFFF: highest legal byte address (bounds-check feature only).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous reset, active low.
- req_valid, input, 1: request present.
- req_ready, output, 1: unit can accept a request (high only in IDLE).
- req_write, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 0 = byte, 1 = half, 2 = word; 3 is reserved and flagged as an error.
- req_signed, input, 1: sign-extend loads (LB/LH); ignored for stores.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned.
- resp_valid, output, 1: one-cycle response pulse.
- resp_rdata, output, 32: extended load data; 0 for stores and errors.
- resp_error, output, 1: misaligned, reserved size, or out of bounds.
- mem_write, output, 1: write strobe to data memory.
- mem_address, output, 32: word address with [1:0] = 0.
- mem_write_data, output, 32: word to write.
- mem_read_data, input, 32: word read.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All of these are 0: mem_write, mem_address, mem_write_data, resp_valid, resp_rdata, resp_error, the wait counter and the captured request.
  - req_ready goes to 1 once reset is released.
- Reset mid-operation aborts the access. Any partial RMW is dropped and no write is issued after release.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. All req_* fields are latched at that edge.
- State machine:
  - IDLE:
    - On accept with an error condition, go to RESP.
    - Otherwise: a word store goes to WRITE; a load or sub-word store goes to READ.
  - READ:
    - mem_address = {addr[31:2], 2'b00} and mem_write = 0.
    - Stay READ_LATENCY cycles, then capture mem_read_data.
    - A load then goes to RESP; a sub-word store goes to WRITE.
  - WRITE:
    - mem_write = 1 for exactly one cycle.
    - mem_write_data = merged word (sub-word store) or req_wdata (word store).
    - Then go to RESP.
  - RESP:
    - resp_valid = 1 for one cycle, then go to IDLE.
    - req_ready is low in READ, WRITE and RESP.
- Latencies from accept to resp_valid:
  - Load: READ_LATENCY+1 cycles.
  - Word store: 2 cycles.
  - Sub-word store: READ_LATENCY+2 cycles.
  - Error: 1 cycle.
- Byte lanes (big-endian): offset 0 maps to bits [31:24], offset 3 to bits [7:0]. Half at offset 0 maps to [31:16], offset 2 to [15:0].
- Merge rule: only the addressed lane(s) are replaced with req_wdata[7:0] or req_wdata[15:0]; other lanes keep the read value.
- Load extension: with req_signed = 1, the lane MSB is replicated into bits 31..8 (byte) or 31..16 (half). With req_signed = 0, those bits are zero.
- Error conditions:
  - Half with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - req_size = 3.
  - An error issues no memory cycle (mem_write stays 0, mem_address unchanged) and gives resp_rdata = 0 with resp_error = 1.
- mem_write is 0 in every state except WRITE.
- mem_address holds its last value in IDLE.
- req_valid held high through RESP is not accepted until the IDLE cycle that follows.
- Address wrap-around: the word address simply truncates (32'hFFFFFFFF maps to word 32'hFFFFFFFC). There is no carry handling.

Optional Feature:
- LSU_BOUNDS_CHECK_EN defined: an address < MEM_BASE or > MEM_LIMIT is an error, handled exactly like misalignment (no memory cycle, resp_error = 1).
- Undefined: the address range is not checked. Out-of-window loads return whatever the memory drives, which is 0 below 32'h70000000.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - the state enum (IDLE, READ, WRITE, RESP);
  - the default MEM_BASE and MEM_LIMIT.
- One sub-module, lsu_lane_mux, is combinational. From offset, size, signed, read word and store data it produces:
  - the merged store word;
  - the extended load data;
  - the misalign flag.
- The FSM, wait counter and registers stay in load_store_unit.

Test Plan:
1. Word store then load (READ_LATENCY = 1): store addr 32'h7FFF0010, data 32'hDEADBEEF.
   - Expect one mem_write pulse with mem_address 32'h7FFF0010.
   - A following load returns 32'hDEADBEEF with resp_valid 2 cycles after accept.
2. Signed/unsigned byte load: memory word 32'h12F45678, addr offset 1.
   - LB returns 32'hFFFFFFF4.
   - LBU returns 32'h000000F4.
3. Byte store RMW: word 32'h11223344, SB offset 2, data 8'hAA.
   - Expect a read cycle, then mem_write_data 32'h1122AA44.
   - The written word reads back identically.
4. Misalignment: LH at 32'h7FFF0001 and SW at 32'h7FFF0002.
   - Each gives resp_error = 1 one cycle after accept, mem_write stays 0, resp_rdata = 0.
5. Reset mid-RMW: assert rst_n low while in READ of an SH.
   - All outputs go to 0 immediately and the target word is unchanged after release.
6. Back-to-back requests: req_valid held high with two loads.
   - The second is accepted only in the IDLE cycle after the first resp_valid.
   - req_ready is low during READ and RESP.
